spi_master_slave: RTL and testbench

- Self-contained SPI link containing one master engine and one slave engine, wired internally (sclk, mosi, miso, ss) and clocked by a single system clock.
- A start pulse makes the master perform one full-duplex DATA_WIDTH-bit exchange: master word goes to the slave, slave word comes back.
- Used as a loopback/bring-up block; the SPI wires are exported as outputs for observation only.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.

---
 rtl/spi_master_slave.sv | 198 +++++++++++++++++++
 tb/tb_spi_master_slave.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_slave.sv
// SPI mode-0 loopback: a master engine and a slave engine share one internal bus.
// A start pulse runs one full-duplex, MSB-first exchange between the two words.
module spi_master_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_m_data_in,
    input  logic [DATA_WIDTH-1:0] i_s_data_in,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_m_data_out,
    output logic [DATA_WIDTH-1:0] o_s_data_out,
    output logic                  o_s_valid,
    output logic                  o_sclk,
    output logic                  o_mosi,
    output logic                  o_miso,
    output logic                  o_ss
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_FINISH} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_m_tx;
    logic [DATA_WIDTH-1:0] r_m_rx;
    logic [DATA_WIDTH-1:0] r_m_data_out;
    logic                  r_sclk;
    logic                  r_ss;
    logic                  r_mosi;
    logic                  r_busy;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] r_s_tx;
    logic [DATA_WIDTH-1:0] r_s_rx;
    logic [DATA_WIDTH-1:0] r_s_data_out;
    logic [CNT_W-1:0]      r_s_cnt;
    logic                  r_miso;
    logic                  r_s_valid;
    logic                  r_sclk_q;
    logic                  r_ss_q;

    logic w_tick;
    logic w_accept;
    logic w_last_fall;
    logic w_finish_end;
    logic w_s_sclk_rise;
    logic w_s_sclk_fall;
    logic w_s_ss_fall;
    logic w_s_ss_rise;

    // Start is refused while done is high so a new transfer begins only after the pulse.
    assign w_tick       = (r_div_cnt == '0);
    assign w_accept     = (r_state == S_IDLE) && i_start && !r_done;
    assign w_last_fall  = (r_state == S_XFER) && w_tick && r_sclk && (r_bit_cnt == '0);
    assign w_finish_end = (r_state == S_FINISH) && w_tick;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)     w_next = S_XFER;
            S_XFER:   if (w_last_fall)  w_next = S_FINISH;
            S_FINISH: if (w_finish_end) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_m_tx       <= '0;
            r_m_rx       <= '0;
            r_m_data_out <= '0;
            r_sclk       <= 1'b0;
            r_ss         <= 1'b1;
            r_mosi       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_m_tx    <= i_m_data_in;
                        r_mosi    <= i_m_data_in[DATA_WIDTH-1];
                        r_m_rx    <= '0;
                        r_ss      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_sclk    <= 1'b0;
                        r_div_cnt <= DIV_W'(CLK_DIV - 1);
                        r_bit_cnt <= CNT_W'(DATA_WIDTH);
                    end
                end
                S_XFER: begin
                    if (!w_tick) begin
                        r_div_cnt <= r_div_cnt - DIV_W'(1);
                    end else if (!r_sclk) begin
                        r_div_cnt <= DIV_W'(CLK_DIV - 1);
                        r_sclk    <= 1'b1;
                        r_m_rx    <= {r_m_rx[DATA_WIDTH-2:0], r_miso};
                        r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                    end else begin
                        r_sclk <= 1'b0;
                        if (r_bit_cnt != '0) begin
                            r_div_cnt <= DIV_W'(CLK_DIV - 1);
                            r_m_tx    <= r_m_tx << 1;
                            r_mosi    <= r_m_tx[DATA_WIDTH-2];
                        end else begin
                            // FINISH holds a full low half-period plus one cycle before done.
                            r_div_cnt <= DIV_W'(CLK_DIV);
                        end
                    end
                end
                S_FINISH: begin
                    if (w_tick) begin
                        r_ss         <= 1'b1;
                        r_busy       <= 1'b0;
                        r_mosi       <= 1'b0;
                        r_m_data_out <= r_m_rx;
                        r_done       <= 1'b1;
                    end else begin
                        r_div_cnt <= r_div_cnt - DIV_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Slave sees the bus one clock late through its own edge-detect registers.
    assign w_s_sclk_rise = r_sclk && !r_sclk_q;
    assign w_s_sclk_fall = !r_sclk && r_sclk_q;
    assign w_s_ss_fall   = !r_ss && r_ss_q;
    assign w_s_ss_rise   = r_ss && !r_ss_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sclk_q     <= 1'b0;
            r_ss_q       <= 1'b1;
            r_s_tx       <= '0;
            r_s_rx       <= '0;
            r_s_cnt      <= '0;
            r_s_data_out <= '0;
            r_miso       <= 1'b0;
            r_s_valid    <= 1'b0;
        end else begin
            r_sclk_q  <= r_sclk;
            r_ss_q    <= r_ss;
            r_s_valid <= 1'b0;
            if (w_s_ss_fall) begin
                r_s_tx  <= i_s_data_in;
                r_miso  <= i_s_data_in[DATA_WIDTH-1];
                r_s_cnt <= '0;
            end else if (w_s_ss_rise) begin
                if (r_s_cnt == CNT_W'(DATA_WIDTH)) begin
                    r_s_data_out <= r_s_rx;
                    r_s_valid    <= 1'b1;
                end
                r_miso <= 1'b0;
            end else if (!r_ss) begin
                if (w_s_sclk_rise) begin
                    r_s_rx  <= {r_s_rx[DATA_WIDTH-2:0], r_mosi};
                    r_s_cnt <= r_s_cnt + CNT_W'(1);
                end else if (w_s_sclk_fall) begin
                    r_s_tx <= r_s_tx << 1;
                    r_miso <= r_s_tx[DATA_WIDTH-2];
                end
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_m_data_out = r_m_data_out;
    assign o_s_data_out = r_s_data_out;
    assign o_s_valid    = r_s_valid;
    assign o_sclk       = r_sclk;
    assign o_mosi       = r_mosi;
    assign o_miso       = r_miso;
    assign o_ss         = r_ss;

endmodule

// File: tb/tb_spi_master_slave.sv
// Self-checking bench for spi_master_slave: default 8-bit instance plus a 16-bit, CLK_DIV=4 instance.
// Expected words, bit sequences and latencies come from the link's stated rules.
module tb_spi_master_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start;
    logic [7:0] m_in, s_in, m_out, s_out;
    logic       busy, done, s_valid, sclk, mosi, miso, ss;

    logic        start16;
    logic [15:0] m_in16, s_in16, m_out16, s_out16;
    logic        busy16, done16, s_valid16, sclk16, mosi16, miso16, ss16;

    int checks = 0;
    int errors = 0;

    spi_master_slave #(.DATA_WIDTH(8), .CLK_DIV(2)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .i_m_data_in(m_in), .i_s_data_in(s_in),
        .o_busy(busy), .o_done(done), .o_m_data_out(m_out), .o_s_data_out(s_out),
        .o_s_valid(s_valid), .o_sclk(sclk), .o_mosi(mosi), .o_miso(miso), .o_ss(ss)
    );

    spi_master_slave #(.DATA_WIDTH(16), .CLK_DIV(4)) u_dut16 (
        .i_clk(clk), .i_reset(reset), .i_start(start16),
        .i_m_data_in(m_in16), .i_s_data_in(s_in16),
        .o_busy(busy16), .o_done(done16), .o_m_data_out(m_out16), .o_s_data_out(s_out16),
        .o_s_valid(s_valid16), .o_sclk(sclk16), .o_mosi(mosi16), .o_miso(miso16), .o_ss(ss16)
    );

    // One 8-bit exchange; inject_at re-asserts start mid-transfer, post = cycles watched after done.
    task automatic run_xfer(input logic [7:0] m, input logic [7:0] s, input int inject_at,
                            input int post, input string tag);
        int   cyc = 0, done_cyc = -1, dones = 0, valids = 0, rises = 0;
        int   bad_mosi = 0, bad_miso = 0, bad_busy = 0;
        logic prev_sclk = 1'b0, busy_at_done = 1'b1, ss_at_done = 1'b0;
        m_in  = m;
        s_in  = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_in  = 8'($urandom);
        while (done_cyc < 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) s_in = 8'($urandom);
            start = (cyc == inject_at);
            if (sclk && !prev_sclk) begin
                if (rises < 8) begin
                    if (mosi !== m[7-rises]) bad_mosi++;
                    if (miso !== s[7-rises]) bad_miso++;
                end
                rises++;
            end
            prev_sclk = sclk;
            if (s_valid) valids++;
            if (done) begin
                dones++;
                done_cyc     = cyc;
                busy_at_done = busy;
                ss_at_done   = ss;
            end else if (!busy || ss) begin
                bad_busy++;
            end
        end
        start = 1'b0;
        for (int i = 0; i < post; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (s_valid) valids++;
        end
        checks++; if (done_cyc !== 35) begin errors++; $display("FAIL %s done_latency got %0d want 35", tag, done_cyc); end
        checks++; if (dones !== 1) begin errors++; $display("FAIL %s done_count got %0d want 1", tag, dones); end
        checks++; if (valids !== 1) begin errors++; $display("FAIL %s s_valid_count got %0d want 1", tag, valids); end
        checks++; if (rises !== 8) begin errors++; $display("FAIL %s sclk_rises got %0d want 8", tag, rises); end
        checks++; if (bad_mosi !== 0) begin errors++; $display("FAIL %s mosi_bits got %0d bad want 0", tag, bad_mosi); end
        checks++; if (bad_miso !== 0) begin errors++; $display("FAIL %s miso_bits got %0d bad want 0", tag, bad_miso); end
        checks++; if (bad_busy !== 0) begin errors++; $display("FAIL %s busy_ss_during got %0d bad cycles want 0", tag, bad_busy); end
        checks++; if (busy_at_done !== 1'b0 || ss_at_done !== 1'b1) begin errors++;
            $display("FAIL %s end_state busy=%b ss=%b want busy=0 ss=1", tag, busy_at_done, ss_at_done); end
        checks++; if (m_out !== s) begin errors++; $display("FAIL %s m_data_out got %h want %h", tag, m_out, s); end
        checks++; if (s_out !== m) begin errors++; $display("FAIL %s s_data_out got %h want %h", tag, s_out, m); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start16 = 1'b0;
        m_in = '0; s_in = '0; m_in16 = '0; s_in16 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({sclk, ss, mosi, miso, busy, done, s_valid} !== 7'b0100000) begin errors++;
            $display("FAIL reset_ctrl got %b want 0100000", {sclk, ss, mosi, miso, busy, done, s_valid}); end
        checks++; if (m_out !== 8'h00 || s_out !== 8'h00) begin errors++;
            $display("FAIL reset_data got %h/%h want 00/00", m_out, s_out); end
        checks++; if ({sclk16, ss16, busy16, done16, s_valid16} !== 5'b01000 || m_out16 !== 16'h0 || s_out16 !== 16'h0) begin errors++;
            $display("FAIL reset_wide got %b %h %h want 01000 0 0", {sclk16, ss16, busy16, done16, s_valid16}, m_out16, s_out16); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_patterns();
        run_xfer(8'hAB, 8'h55, -1, 3, "ab_55");
        run_xfer(8'hFF, 8'h00, -1, 3, "ff_00");
        run_xfer(8'h00, 8'hFF, -1, 3, "00_ff");
        run_xfer(8'h81, 8'h7E, -1, 3, "81_7e");
    endtask

    task automatic test_start_while_busy();
        run_xfer(8'hC5, 8'h3A, 10, 3, "start_busy");
    endtask

    task automatic test_back_to_back();
        run_xfer(8'h12, 8'h34, -1, 1, "b2b_first");
        run_xfer(8'h56, 8'h78, -1, 3, "b2b_second");
    endtask

    task automatic test_reset_mid();
        int cyc = 0, pulses = 0;
        m_in = 8'hA5; s_in = 8'h5A; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 15) begin @(posedge clk); #1; cyc++; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if ({ss, sclk, busy, mosi, miso} !== 5'b10000) begin errors++;
            $display("FAIL reset_mid_ctrl got ss,sclk,busy,mosi,miso=%b want 10000", {ss, sclk, busy, mosi, miso}); end
        checks++; if (m_out !== 8'h00 || s_out !== 8'h00) begin errors++;
            $display("FAIL reset_mid_data got %h/%h want 00/00", m_out, s_out); end
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done || s_valid || busy) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_mid_pulses got %0d want 0", pulses); end
        run_xfer(8'h3C, 8'hC3, -1, 3, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            run_xfer(a, b, -1, 3, "random");
        end
    endtask

    task automatic test_wide();
        int   cyc = 0, done_cyc = -1, first_rise = -1, first_fall = -1, rises = 0, bad_mosi = 0, valids = 0;
        logic prev = 1'b0;
        logic [15:0] m, s;
        m = 16'hBEEF; s = 16'h1234;
        m_in16 = m; s_in16 = s; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        m_in16 = 16'($urandom);
        while (done_cyc < 0 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) s_in16 = 16'($urandom);
            if (sclk16 && !prev) begin
                if (first_rise < 0) first_rise = cyc;
                if (rises < 16 && mosi16 !== m[15-rises]) bad_mosi++;
                rises++;
            end
            if (!sclk16 && prev && first_fall < 0) first_fall = cyc;
            prev = sclk16;
            if (done16) done_cyc = cyc;
        end
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (s_valid16) valids++; end
        checks++; if (done_cyc !== 133) begin errors++; $display("FAIL wide_done_latency got %0d want 133", done_cyc); end
        checks++; if (first_rise !== 4 || first_fall !== 8) begin errors++;
            $display("FAIL wide_half_period rise@%0d fall@%0d want 4 and 8", first_rise, first_fall); end
        checks++; if (rises !== 16 || bad_mosi !== 0) begin errors++;
            $display("FAIL wide_bits rises=%0d bad_mosi=%0d want 16 and 0", rises, bad_mosi); end
        checks++; if (m_out16 !== s || s_out16 !== m || valids !== 1) begin errors++;
            $display("FAIL wide_data got %h/%h valid=%0d want %h/%h valid=1", m_out16, s_out16, valids, s, m); end
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (ss !== 1'b1 || sclk !== 1'b0 || miso !== 1'b0 || done || s_valid || busy) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_wide();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
